data_sram_responder: RTL and testbench

- Slave end of the CPU data SRAM interface (en / we[3:0] / addr / wdata / rdata).
- Responds with a fixed 1-cycle read latency, matching what the pipeline's MEM stage expects.
- Decodes each request either to a word-addressed local RAM or to a small MMIO confreg window: timer, LEDs, seven-segment number, switches and a simulation flag.
- Sits between mycpu_top's data port and the board/testbench, beside the instruction RAM.

---
 rtl/data_sram_responder.sv | 120 ++++++++++++
 tb/tb_data_sram_responder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// Slave end of the CPU data SRAM port: 1-cycle registered read latency, backed by a local
// word-addressed RAM and a small confreg MMIO window (timer, LED, NUM, switches, sim flag).
module data_sram_responder #(
    parameter int unsigned RAM_AW     = 16,
    parameter logic [31:0] MMIO_BASE  = 32'hBFAF_0000,
    parameter bit          SIMULATION = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch,
    output logic [15:0] led,
    output logic [31:0] num_data
);

    localparam logic [15:0] OffTimer   = 16'hE000;
    localparam logic [15:0] OffLed     = 16'hF020;
    localparam logic [15:0] OffNum     = 16'hF050;
    localparam logic [15:0] OffSwitch  = 16'hF060;
    localparam logic [15:0] OffSimFlag = 16'hF0F0;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    logic              is_mmio;
    logic [15:0]       mmio_off;
    logic [RAM_AW-1:0] ram_idx;
    logic              wr_req;
    logic              rd_req;
    logic              unused_addr;

    assign is_mmio     = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
    assign mmio_off    = {data_sram_addr[15:2], 2'b00};
    assign ram_idx     = data_sram_addr[RAM_AW+1:2];
    assign wr_req      = data_sram_en && (data_sram_we != 4'b0000);
    assign rd_req      = data_sram_en && (data_sram_we == 4'b0000);
    assign unused_addr = ^data_sram_addr[1:0];

    logic [31:0] mem [2**RAM_AW];

    logic [31:0] timer_q, timer_d;
    logic [15:0] led_q, led_d;
    logic [31:0] num_q, num_d;
    logic [7:0]  sw_meta_q, sw_sync_q;
    logic [31:0] rdata_q;
    logic [31:0] mmio_rdata;
    logic [31:0] led_merged;

    // A timer write overrides the free-running increment for that edge.
    always_comb begin
        timer_d    = timer_q + 32'd1;
        led_d      = led_q;
        num_d      = num_q;
        led_merged = byte_merge({16'h0000, led_q}, data_sram_wdata, data_sram_we);
        if (wr_req && is_mmio) begin
            case (mmio_off)
                OffTimer: timer_d = byte_merge(timer_q, data_sram_wdata, data_sram_we);
                OffLed:   led_d   = led_merged[15:0];
                OffNum:   num_d   = byte_merge(num_q, data_sram_wdata, data_sram_we);
                default:  ;
            endcase
        end
    end

    always_comb begin
        case (mmio_off)
            OffTimer:   mmio_rdata = timer_q;
            OffLed:     mmio_rdata = {16'h0000, led_q};
            OffNum:     mmio_rdata = num_q;
            OffSwitch:  mmio_rdata = {24'h000000, sw_sync_q};
            OffSimFlag: mmio_rdata = {32{SIMULATION}};
            default:    mmio_rdata = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q   <= 32'h0;
            led_q     <= 16'h0;
            num_q     <= 32'h0;
            sw_meta_q <= 8'h0;
            sw_sync_q <= 8'h0;
            rdata_q   <= 32'h0;
        end else begin
            timer_q   <= timer_d;
            led_q     <= led_d;
            num_q     <= num_d;
            sw_meta_q <= switch;
            sw_sync_q <= sw_meta_q;
            if (rd_req) rdata_q <= is_mmio ? mmio_rdata : mem[ram_idx];
        end
    end

    // RAM contents survive reset; reset only blocks writes issued while it is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
        end else if (wr_req && !is_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_we[i]) mem[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
        end
    end

    assign data_sram_rdata = rdata_q;
    assign led             = led_q;
    assign num_data        = num_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder: driver pushes expected read data from a
// behavioural model; a negedge monitor pops and compares, and also checks hold/LED/NUM.
module tb_data_sram_responder;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        en    = 1'b0;
    logic [3:0]  we    = 4'h0;
    logic [31:0] addr  = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic [7:0]  sw    = 8'h0;
    logic [15:0] led;
    logic [31:0] num;

    always #5 clk = ~clk;

    data_sram_responder dut (
        .clk             (clk),
        .reset           (reset),
        .data_sram_en    (en),
        .data_sram_we    (we),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .switch          (sw),
        .led             (led),
        .num_data        (num)
    );

    typedef struct {
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          tedge = 0;
    int          sync_from = 0;
    logic [31:0] tbase = 32'h0;
    logic [15:0] led_m = 16'h0;
    logic [31:0] num_m = 32'h0;
    logic [31:0] mem_m [int];
    logic [7:0]  sw_at [int];
    logic [31:0] last_val = 32'h0;
    logic        rd_seen = 1'b0;
    bit          finish_req = 1'b0;
    bit          drained = 1'b0;

    // ---------------- reference model ----------------
    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    // Value the bus returns for a read sampled at edge c.
    function automatic logic [31:0] model_read(input logic [31:0] a, input int c);
        int idx;
        if (a[31:16] != 16'hBFAF) begin
            idx = int'({16'h0, a[17:2]});
            return mem_m.exists(idx) ? mem_m[idx] : 32'h0;
        end
        case ({a[15:2], 2'b00})
            16'hE000: return tbase + 32'(c - tedge);
            16'hF020: return {16'h0, led_m};
            16'hF050: return num_m;
            16'hF060: return (c - 2 >= sync_from && sw_at.exists(c - 2)) ?
                             {24'h0, sw_at[c - 2]} : 32'h0;
            16'hF0F0: return 32'hFFFF_FFFF;
            default:  return 32'h0;
        endcase
    endfunction

    // Apply a write that committed at edge w.
    function automatic void model_write(input logic [31:0] a, input logic [3:0] be,
                                        input logic [31:0] d, input int w);
        int          idx;
        logic [31:0] cur;
        if (a[31:16] != 16'hBFAF) begin
            idx = int'({16'h0, a[17:2]});
            cur = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
            mem_m[idx] = merge(cur, d, be);
            return;
        end
        case ({a[15:2], 2'b00})
            16'hE000: begin
                cur   = tbase + 32'(w - tedge);
                tbase = merge(cur, d, be);
                tedge = w + 1;
            end
            16'hF020: begin
                cur   = merge({16'h0, led_m}, d, be);
                led_m = cur[15:0];
            end
            16'hF050: num_m = merge(num_m, d, be);
            default: ;
        endcase
    endfunction

    // ---------------- monitor ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, expv);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) rd_seen <= 1'b0;
        else       rd_seen <= en && (we == 4'h0);
    end

    always @(negedge clk or posedge reset) begin
        exp_t e;
        if (reset) begin
            #1;
            chk("reset_rdata", rdata, 32'h0);
            chk("reset_led", {16'h0, led}, 32'h0);
            chk("reset_num", num, 32'h0);
            last_val = 32'h0;
        end else begin
            if (rd_seen) begin
                if (exp_q.size() == 0) begin
                    chk("read_queue_size", exp_q.size(), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk(e.name, rdata, e.val);
                    last_val = e.val;
                end
            end else begin
                chk("rdata_hold", rdata, last_val);
            end
            chk("led", {16'h0, led}, {16'h0, led_m});
            chk("num_data", num, num_m);
            if (finish_req && !drained) begin
                chk("queue_drain", exp_q.size(), 32'd0);
                drained = 1'b1;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic e, input logic [3:0] be, input logic [31:0] a,
                         input logic [31:0] d, input string nm, input bit ovr,
                         input logic [31:0] ov);
        en    = e;
        we    = be;
        addr  = a;
        wdata = d;
        if (e && be == 4'h0 && !reset) exp_q.push_back('{ovr ? ov : model_read(a, cyc + 1), nm});
        @(posedge clk);
        cyc++;
        sw_at[cyc] = sw;
        if (e && be != 4'h0 && !reset) model_write(a, be, d, cyc);
        #2;
    endtask

    task automatic idle();
        issue(1'b0, 4'h0, 32'h0, 32'h0, "idle", 1'b0, 32'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        issue(1'b1, be, a, d, "write", 1'b0, 32'h0);
    endtask

    task automatic rd(input logic [31:0] a, input string nm);
        issue(1'b1, 4'h0, a, 32'h0, nm, 1'b0, 32'h0);
    endtask

    task automatic rdx(input logic [31:0] a, input string nm, input logic [31:0] v);
        issue(1'b1, 4'h0, a, 32'h0, nm, 1'b1, v);
    endtask

    task automatic release_rst();
        reset     = 1'b0;
        tbase     = 32'h0;
        tedge     = cyc + 1;
        sync_from = cyc + 1;
    endtask

    function automatic logic [31:0] rand_ram_addr(input int k);
        return {14'($urandom), 16'h0400 + 16'(k), 2'($urandom)};
    endfunction

    initial begin
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 release_rst();

        // Reset mid-run, with a request issued while reset is held
        wr(32'h0000_0100, 4'hF, 32'h0BAD_F00D);
        wr(32'hBFAF_E000, 4'hF, 32'h0000_0055);
        wr(32'hBFAF_F020, 4'hF, 32'h0000_00FF);
        wr(32'hBFAF_F050, 4'hF, 32'h0000_0077);
        idle();
        reset = 1'b1;
        led_m = 16'h0;
        num_m = 32'h0;
        wr(32'h0000_0100, 4'hF, 32'hDEAD_0000);
        rd(32'h0000_0100, "read_during_reset");
        release_rst();
        repeat (5) idle();
        rdx(32'hBFAF_E000, "timer_after_reset", 32'd5);
        rdx(32'h0000_0100, "ram_not_written_in_reset", 32'h0BAD_F00D);

        // RAM byte merge
        wr(32'h1C00_0040, 4'hF, 32'h1122_3344);
        wr(32'h1C00_0040, 4'b0101, 32'hAABB_CCDD);
        rdx(32'h1C00_0040, "ram_byte_merge", 32'h11BB_33DD);
        idle();
        idle();

        // Timer write and wrap
        wr(32'hBFAF_E000, 4'hF, 32'hFFFF_FFFE);
        rdx(32'hBFAF_E000, "timer_t1", 32'hFFFF_FFFE);
        rdx(32'hBFAF_E000, "timer_t2", 32'hFFFF_FFFF);
        rdx(32'hBFAF_E000, "timer_wrap", 32'h0000_0000);

        // LED / NUM
        wr(32'hBFAF_F020, 4'hF, 32'hDEAD_BEEF);
        rdx(32'hBFAF_F020, "led_read", 32'h0000_BEEF);
        wr(32'hBFAF_F050, 4'b1000, 32'h1234_5678);
        rdx(32'hBFAF_F050, "num_read", 32'h1200_0000);

        // Switch synchronizer latency, sim flag, unmapped offset
        sw = 8'hA5;
        rdx(32'hBFAF_F060, "switch_lat1", 32'h0);
        rdx(32'hBFAF_F060, "switch_lat2", 32'h0);
        rdx(32'hBFAF_F060, "switch_lat3", 32'h0000_00A5);
        repeat (3) idle();
        rdx(32'hBFAF_F060, "switch_held", 32'h0000_00A5);
        rdx(32'hBFAF_F0F0, "simu_flag", 32'hFFFF_FFFF);
        wr(32'h0003_F100, 4'hF, 32'h600D_CAFE);
        wr(32'hBFAF_F100, 4'hF, 32'h0000_0001);
        rdx(32'hBFAF_F100, "unmapped_read", 32'h0);
        rdx(32'h0003_F100, "unmapped_no_ram_alias", 32'h600D_CAFE);

        // Back-to-back reads
        for (int i = 0; i < 4; i++) wr(32'h0000_0200 + 32'(4 * i), 4'hF, 32'(i + 1));
        for (int i = 0; i < 4; i++) rdx(32'h0000_0200 + 32'(4 * i), "b2b_read", 32'(i + 1));

        // Randomized traffic over a small aliased RAM set and the MMIO window
        for (int k = 0; k < 8; k++) wr(rand_ram_addr(k), 4'hF, $urandom);
        for (int n = 0; n < 400; n++) begin
            logic [3:0]  be;
            logic [31:0] a;
            logic        e;
            if ($urandom_range(9) == 0) sw = 8'($urandom);
            be = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom);
            e  = ($urandom_range(7) != 0);
            if ($urandom_range(2) == 0) begin
                case ($urandom_range(6))
                    0:       a = 32'hBFAF_E000;
                    1:       a = 32'hBFAF_F020;
                    2:       a = 32'hBFAF_F050;
                    3:       a = 32'hBFAF_F060;
                    4:       a = 32'hBFAF_F0F0;
                    5:       a = 32'hBFAF_F100;
                    default: a = {16'hBFAF, 16'($urandom)};
                endcase
            end else begin
                a = rand_ram_addr(int'($urandom_range(7)));
            end
            issue(e, be, a, $urandom, "random_read", 1'b0, 32'h0);
        end

        idle();
        finish_req = 1'b1;
        repeat (3) idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
